// File: rtl/wclk_rptr_sync_status_if.sv
// ---------------------------------------------------------------------------
// wclk_rptr_sync_status_if
// Groups the pointer and status signals of the write-clock end of the async
// FIFO pointer crossing. Clock and reset stay plain ports on the module.
//
// Signals (widths from ADDR_W; pointers carry one extra wrap bit):
//   wptr_bin        binary write pointer        (write logic -> block)
//   rptr_gray_async Gray read pointer, rclk-launched (read side -> block)
//   wptr_gray       registered Gray write pointer   (block -> read side)
//   rptr_bin_sync   synchronized binary read pointer (block -> write logic)
//   wlevel          write-side fill level, 0..DEPTH
//   full            wlevel == DEPTH
//   almost_full     wlevel >= AF_THRESH
//   ptr_err         sticky pointer-integrity error (only with WCLK_PTR_CHECK_EN)
//
// Modports: master = write-side environment, slave = wclk_rptr_sync_status.
// ---------------------------------------------------------------------------
interface wclk_rptr_sync_status_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W:0] wptr_bin;
  logic [ADDR_W:0] rptr_gray_async;
  logic [ADDR_W:0] wptr_gray;
  logic [ADDR_W:0] rptr_bin_sync;
  logic [ADDR_W:0] wlevel;
  logic            full;
  logic            almost_full;
`ifdef WCLK_PTR_CHECK_EN
  logic            ptr_err;
`endif

  modport master (
    output wptr_bin,
    output rptr_gray_async,
    input  wptr_gray,
    input  rptr_bin_sync,
    input  wlevel,
    input  full,
`ifdef WCLK_PTR_CHECK_EN
    input  ptr_err,
`endif
    input  almost_full
  );

  modport slave (
    input  wptr_bin,
    input  rptr_gray_async,
    output wptr_gray,
    output rptr_bin_sync,
    output wlevel,
    output full,
`ifdef WCLK_PTR_CHECK_EN
    output ptr_err,
`endif
    output almost_full
  );
endinterface

// File: rtl/wclk_rptr_sync_status.sv
// ---------------------------------------------------------------------------
// wclk_rptr_sync_status
// Write-clock end of the async FIFO pointer crossing:
//   - Gray-encodes the binary write pointer into a launch flop for the read
//     domain (flop drives the port directly, no logic after it).
//   - Synchronizes the Gray read pointer through SYNC_STAGES flops, decodes it
//     to binary and registers it (SYNC_STAGES+1 wclk edges of latency).
//   - Derives the write-side level and full / almost_full combinationally.
//
// Ports:
//   wclk    write clock
//   wreset  asynchronous, active-high reset (clears all flops immediately)
//   bus     wclk_rptr_sync_status_if.slave (pointers, level, flags)
//
// Parameters: ADDR_W (depth 2**ADDR_W), SYNC_STAGES (2..4), AF_THRESH (1..DEPTH)
//
// Optional feature macro WCLK_PTR_CHECK_EN: adds sticky bus.ptr_err, set when
// the synchronized Gray pointer moves by more than one bit between cycles or
// when the level exceeds DEPTH. Cleared only by wreset.
// ---------------------------------------------------------------------------
module wclk_rptr_sync_status #(
  parameter int ADDR_W      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 3
) (
  input  logic                  wclk,
  input  logic                  wreset,
  wclk_rptr_sync_status_if.slave bus
);

  localparam int              PW      = ADDR_W + 1;
  localparam int              LAST    = SYNC_STAGES - 1;
  localparam logic [PW-1:0]   DEPTH_L = PW'(2 ** ADDR_W);
  localparam logic [PW-1:0]   AF_L    = PW'(AF_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wptr_gray_q,     wptr_gray_d;
  logic [PW-1:0] rptr_bin_sync_q, rptr_bin_sync_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wlevel_c;

  assign wptr_gray_d     = bin2gray(bus.wptr_bin);
  assign rptr_bin_sync_d = gray2bin(sync_q[LAST]);

  // Launch flop for the read domain: only the Gray value may cross.
  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      wptr_gray_q <= '0;
    end else begin
      wptr_gray_q <= wptr_gray_d;
    end
  end

  // Synchronizer: stage 0 samples the async Gray pointer with no logic in front.
  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rptr_bin_sync_q <= '0;
    end else begin
      sync_q[0] <= bus.rptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rptr_bin_sync_q <= rptr_bin_sync_d;
    end
  end

  // Unsigned modular difference handles pointer wrap with no special case.
  // The read pointer is stale, so the level can only over-report occupancy.
  assign wlevel_c = bus.wptr_bin - rptr_bin_sync_q;

  assign bus.wptr_gray     = wptr_gray_q;
  assign bus.rptr_bin_sync = rptr_bin_sync_q;
  assign bus.wlevel        = wlevel_c;
  assign bus.full          = (wlevel_c == DEPTH_L);
  assign bus.almost_full   = (wlevel_c >= AF_L);

`ifdef WCLK_PTR_CHECK_EN
  logic [PW-1:0] gray_prev_q;
  logic [PW-1:0] gray_diff;
  logic          multi_bit;
  logic          ptr_err_q, ptr_err_d;

  // More than one bit set in the diff <=> diff & (diff-1) is non-zero.
  assign gray_diff = sync_q[LAST] ^ gray_prev_q;
  assign multi_bit = (gray_diff & (gray_diff - PW'(1))) != '0;
  assign ptr_err_d = ptr_err_q | multi_bit | (wlevel_c > DEPTH_L);

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      gray_prev_q <= '0;
      ptr_err_q   <= 1'b0;
    end else begin
      gray_prev_q <= sync_q[LAST];
      ptr_err_q   <= ptr_err_d;
    end
  end

  assign bus.ptr_err = ptr_err_q;
`endif

endmodule

// File: tb/tb_wclk_rptr_sync_status.sv
module tb_wclk_rptr_sync_status;

  logic wclk   = 1'b0;
  logic wreset = 1'b0;
  logic clk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  wclk_rptr_sync_status_if #(.ADDR_W(2)) bus ();

  wclk_rptr_sync_status #(
    .ADDR_W      (2),
    .SYNC_STAGES (2),
    .AF_THRESH   (3)
  ) dut (
    .wclk   (wclk),
    .wreset (wreset),
    .bus    (bus)
  );

  always #5 if (clk_en) wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  logic [2:0] gray_exp [5];
  initial begin
    gray_exp[0] = 3'b000; gray_exp[1] = 3'b001; gray_exp[2] = 3'b011;
    gray_exp[3] = 3'b010; gray_exp[4] = 3'b110;
  end

  initial begin
    bus.wptr_bin        = '0;
    bus.rptr_gray_async = '0;

    // Load non-zero state first so the reset check means something.
    clk_en = 1'b1;
    bus.wptr_bin        = 3'd5;
    bus.rptr_gray_async = 3'b011;
    tick(4);
    check("pre_wptr_gray", 32'(bus.wptr_gray), 32'd7);
    check("pre_rptr_bin", 32'(bus.rptr_bin_sync), 32'd2);

    // Reset with clock stopped: must clear at once.
    clk_en = 1'b0;
    #2;
    bus.wptr_bin = '0;
    wreset = 1'b1;
    #1;
    check("rst_wptr_gray", 32'(bus.wptr_gray), 32'd0);
    check("rst_rptr_bin", 32'(bus.rptr_bin_sync), 32'd0);
    check("rst_wlevel", 32'(bus.wlevel), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_af", 32'(bus.almost_full), 32'd0);
`ifdef WCLK_PTR_CHECK_EN
    check("rst_ptr_err", 32'(bus.ptr_err), 32'd0);
`endif
    #3;
    bus.rptr_gray_async = 3'b000;
    wreset = 1'b0;
    clk_en = 1'b1;
    tick(4);

    // Fill: level tracks wptr_bin with no latency; Gray follows one edge later.
    for (int v = 0; v <= 4; v++) begin
      bus.wptr_bin = 3'(v);
      #1;
      check($sformatf("fill_wlevel_%0d", v), 32'(bus.wlevel), 32'(v));
      check($sformatf("fill_af_%0d", v), 32'(bus.almost_full), (v >= 3) ? 32'd1 : 32'd0);
      check($sformatf("fill_full_%0d", v), 32'(bus.full), (v == 4) ? 32'd1 : 32'd0);
      tick(1);
      check($sformatf("fill_gray_%0d", v), 32'(bus.wptr_gray), 32'(gray_exp[v]));
    end

    // Read release: three edges from input change to decoded pointer.
    bus.rptr_gray_async = 3'b001;
    tick(2);
    check("rel_rptr_t2", 32'(bus.rptr_bin_sync), 32'd0);
    check("rel_full_t2", 32'(bus.full), 32'd1);
    tick(1);
    check("rel_rptr_t3", 32'(bus.rptr_bin_sync), 32'd1);
    check("rel_wlevel_t3", 32'(bus.wlevel), 32'd3);
    check("rel_full_t3", 32'(bus.full), 32'd0);
    check("rel_af_t3", 32'(bus.almost_full), 32'd1);

    // Wrap: wptr=1, rptr=6 -> level (1-6) mod 8 = 3.
    bus.wptr_bin        = 3'b001;
    bus.rptr_gray_async = 3'b101;
    tick(4);
    check("wrap_rptr", 32'(bus.rptr_bin_sync), 32'd6);
    check("wrap_wlevel", 32'(bus.wlevel), 32'd3);
    check("wrap_af", 32'(bus.almost_full), 32'd1);
    check("wrap_full", 32'(bus.full), 32'd0);
    check("wrap_gray", 32'(bus.wptr_gray), 32'd1);

    // Reset mid-operation between edges.
    #2;
    wreset = 1'b1;
    #1;
    check("mid_rst_rptr", 32'(bus.rptr_bin_sync), 32'd0);
    check("mid_rst_gray", 32'(bus.wptr_gray), 32'd0);
    @(negedge wclk);
    wreset = 1'b0;
    tick(2);
    check("resync_t2", 32'(bus.rptr_bin_sync), 32'd0);
    tick(1);
    check("resync_t3", 32'(bus.rptr_bin_sync), 32'd6);

`ifdef WCLK_PTR_CHECK_EN
    // Two-bit jump on the synchronized Gray pointer.
    @(negedge wclk);
    wreset = 1'b1;
    bus.wptr_bin        = 3'd0;
    bus.rptr_gray_async = 3'b000;
    #1;
    wreset = 1'b0;
    tick(4);
    check("chk_err_clean", 32'(bus.ptr_err), 32'd0);
    bus.rptr_gray_async = 3'b011;
    tick(2);
    check("chk_err_t2", 32'(bus.ptr_err), 32'd0);
    tick(1);
    check("chk_err_t3", 32'(bus.ptr_err), 32'd1);
    bus.rptr_gray_async = 3'b000;
    tick(5);
    check("chk_err_sticky", 32'(bus.ptr_err), 32'd1);
    @(negedge wclk);
    wreset = 1'b1;
    #1;
    check("chk_err_rst", 32'(bus.ptr_err), 32'd0);
    wreset = 1'b0;

    // Legal single-bit steps with a consistent write pointer.
    bus.wptr_bin = 3'd4;
    tick(4);
    bus.rptr_gray_async = 3'b001;
    tick(4);
    check("chk_legal_1", 32'(bus.ptr_err), 32'd0);
    bus.rptr_gray_async = 3'b011;
    tick(4);
    check("chk_legal_2", 32'(bus.ptr_err), 32'd0);
    bus.rptr_gray_async = 3'b010;
    tick(4);
    check("chk_legal_3", 32'(bus.ptr_err), 32'd0);
    check("chk_legal_lvl", 32'(bus.wlevel), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
